// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared encodings for the ID/EX pipeline register.
//   - ALU_* : 4-bit ALU op codes used across the core (ALU_NOP marks a bubble,
//             ALU_INVALID marks an undecodable instruction).
//   - OPA_* : operand-A source select (2-bit).
//   - OPB_* : operand-B source select (2-bit).
//   - ST_*  : ID/EX occupancy states (the state bit is the stage's valid flag).
package id_ex_stage_pkg;

  typedef logic [3:0] alu_op_t;
  typedef logic [1:0] opsel_t;

  localparam alu_op_t ALU_ADD     = 4'h0;
  localparam alu_op_t ALU_SUB     = 4'h1;
  localparam alu_op_t ALU_AND     = 4'h2;
  localparam alu_op_t ALU_OR      = 4'h3;
  localparam alu_op_t ALU_XOR     = 4'h4;
  localparam alu_op_t ALU_SLL     = 4'h5;
  localparam alu_op_t ALU_SRL     = 4'h6;
  localparam alu_op_t ALU_SRA     = 4'h7;
  localparam alu_op_t ALU_SLT     = 4'h8;
  localparam alu_op_t ALU_SLTU    = 4'h9;
  localparam alu_op_t ALU_PASSB   = 4'hA;
  localparam alu_op_t ALU_NOP     = 4'hE;
  localparam alu_op_t ALU_INVALID = 4'hF;

  localparam opsel_t OPA_RS1  = 2'd0;
  localparam opsel_t OPA_PC   = 2'd1;
  localparam opsel_t OPA_ZERO = 2'd2;

  localparam opsel_t OPB_RS2  = 2'd0;
  localparam opsel_t OPB_IMM  = 2'd1;
  localparam opsel_t OPB_FOUR = 2'd2;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// id_ex_stage_fwd_mux: selects the value of one source register for EX.
// Build option: ID_EX_FWD_EN enables forwarding from EX/MEM and MEM/WB;
// without it the registered value is passed through (x0 still reads as 0).
// Ports:
//   rs_addr_i / rs_data_i           registered source index and read data
//   mem_we_i / mem_rd_i / mem_data_i EX/MEM forward source
//   wb_we_i / wb_rd_i / wb_data_i    MEM/WB write-back source
//   fwd_data_o                       selected operand value
module id_ex_stage_fwd_mux #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [XLEN-1:0]   rs_data_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic [XLEN-1:0]   fwd_data_o
);

`ifdef ID_EX_FWD_EN
  // Youngest producer (EX/MEM) wins over the older MEM/WB value.
  always_comb begin
    fwd_data_o = rs_data_i;
    if (rs_addr_i == '0) begin
      fwd_data_o = '0;
    end else if (mem_we_i && (mem_rd_i == rs_addr_i)) begin
      fwd_data_o = mem_data_i;
    end else if (wb_we_i && (wb_rd_i == rs_addr_i)) begin
      fwd_data_o = wb_data_i;
    end
  end
`else
  // Forward ports stay on the interface but are intentionally ignored.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{mem_we_i, mem_rd_i, mem_data_i, wb_we_i, wb_rd_i, wb_data_i};

  always_comb begin
    fwd_data_o = rs_data_i;
    if (rs_addr_i == '0) begin
      fwd_data_o = '0;
    end
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
// Holds one decoded instruction behind a valid/ready handshake, resolves RAW
// hazards on its source operands and drives ALU operands plus sideband data.
// Build option: ID_EX_FWD_EN enables forwarding and hold-refresh.
// Ports:
//   clk, rst (async, active high), flush_i (drop held/incoming instruction)
//   in_valid_i/in_ready_o + pc/rs/imm/rd/control inputs from decode
//   mem_fwd_*/wb_fwd_* forward sources from EX/MEM and MEM/WB
//   out_valid_o/out_ready_i + alu_a/alu_b/alu_sel/store_data/rd/reg_write/pc
//   illegal_o: held instruction decoded as ALU_INVALID
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              reg_write_i,
  input  logic [3:0]        alu_sel_i,
  input  logic [1:0]        opa_sel_i,
  input  logic [1:0]        opb_sel_i,
  input  logic              mem_fwd_we_i,
  input  logic [REG_AW-1:0] mem_fwd_rd_i,
  input  logic [XLEN-1:0]   mem_fwd_data_i,
  input  logic              wb_fwd_we_i,
  input  logic [REG_AW-1:0] wb_fwd_rd_i,
  input  logic [XLEN-1:0]   wb_fwd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   alu_a_o,
  output logic [XLEN-1:0]   alu_b_o,
  output logic [3:0]        alu_sel_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_write_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              illegal_o
);
  import id_ex_stage_pkg::*;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [REG_AW-1:0] r_rs1_addr;
  logic [REG_AW-1:0] r_rs2_addr;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rd_addr;
  logic              r_reg_write;
  logic [3:0]        r_alu_sel;
  logic [1:0]        r_opa_sel;
  logic [1:0]        r_opb_sel;

  logic              w_capture;
  logic              w_drain;
  logic              w_refresh_rs1;
  logic              w_refresh_rs2;
  logic [XLEN-1:0]   w_rs1_val;
  logic [XLEN-1:0]   w_rs2_val;

  assign in_ready_o = (r_valid == ST_EMPTY) || out_ready_i;
  assign w_capture  = in_valid_i && in_ready_o;
  assign w_drain    = (r_valid == ST_FULL) && out_ready_i;

`ifdef ID_EX_FWD_EN
  // A value retiring through WB while we stall would otherwise be lost once it
  // leaves the forward path, so fold it into the held register.
  assign w_refresh_rs1 = (r_valid == ST_FULL) && !out_ready_i && wb_fwd_we_i &&
                         (wb_fwd_rd_i == r_rs1_addr) && (r_rs1_addr != '0);
  assign w_refresh_rs2 = (r_valid == ST_FULL) && !out_ready_i && wb_fwd_we_i &&
                         (wb_fwd_rd_i == r_rs2_addr) && (r_rs2_addr != '0);
`else
  assign w_refresh_rs1 = 1'b0;
  assign w_refresh_rs2 = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= ST_EMPTY;
      r_pc        <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rd_addr   <= '0;
      r_reg_write <= 1'b0;
      r_alu_sel   <= ALU_NOP;
      r_opa_sel   <= '0;
      r_opb_sel   <= '0;
    end else begin
      // Refresh only happens while stalled, when no capture can occur.
      if (w_refresh_rs1) r_rs1_data <= wb_fwd_data_i;
      if (w_refresh_rs2) r_rs2_data <= wb_fwd_data_i;

      if (flush_i) begin
        r_valid   <= ST_EMPTY;
        r_alu_sel <= ALU_NOP;
      end else if (w_capture) begin
        r_valid     <= ST_FULL;
        r_pc        <= pc_i;
        r_rs1_addr  <= rs1_addr_i;
        r_rs2_addr  <= rs2_addr_i;
        r_rs1_data  <= rs1_data_i;
        r_rs2_data  <= rs2_data_i;
        r_imm       <= imm_i;
        r_rd_addr   <= rd_addr_i;
        r_reg_write <= reg_write_i;
        r_alu_sel   <= alu_sel_i;
        r_opa_sel   <= opa_sel_i;
        r_opb_sel   <= opb_sel_i;
      end else if (w_drain) begin
        r_valid <= ST_EMPTY;
      end
    end
  end

  id_ex_stage_fwd_mux #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_rs1 (
    .rs_addr_i  (r_rs1_addr),
    .rs_data_i  (r_rs1_data),
    .mem_we_i   (mem_fwd_we_i),
    .mem_rd_i   (mem_fwd_rd_i),
    .mem_data_i (mem_fwd_data_i),
    .wb_we_i    (wb_fwd_we_i),
    .wb_rd_i    (wb_fwd_rd_i),
    .wb_data_i  (wb_fwd_data_i),
    .fwd_data_o (w_rs1_val)
  );

  id_ex_stage_fwd_mux #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_rs2 (
    .rs_addr_i  (r_rs2_addr),
    .rs_data_i  (r_rs2_data),
    .mem_we_i   (mem_fwd_we_i),
    .mem_rd_i   (mem_fwd_rd_i),
    .mem_data_i (mem_fwd_data_i),
    .wb_we_i    (wb_fwd_we_i),
    .wb_rd_i    (wb_fwd_rd_i),
    .wb_data_i  (wb_fwd_data_i),
    .fwd_data_o (w_rs2_val)
  );

  always_comb begin
    alu_a_o = '0;
    case (r_opa_sel)
      OPA_RS1: alu_a_o = w_rs1_val;
      OPA_PC:  alu_a_o = r_pc;
      default: alu_a_o = '0;
    endcase
  end

  always_comb begin
    alu_b_o = '0;
    case (r_opb_sel)
      OPB_RS2:  alu_b_o = w_rs2_val;
      OPB_IMM:  alu_b_o = r_imm;
      OPB_FOUR: alu_b_o = XLEN'(4);
      default:  alu_b_o = '0;
    endcase
  end

  assign out_valid_o  = r_valid;
  assign alu_sel_o    = r_valid ? r_alu_sel : ALU_NOP;
  assign reg_write_o  = r_valid && r_reg_write;
  assign illegal_o    = r_valid && (r_alu_sel == ALU_INVALID);
  assign store_data_o = w_rs2_val;
  assign rd_addr_o    = r_rd_addr;
  assign pc_o         = r_pc;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and the ALU in the execute stage.
- Accepts decoded operands and control over a valid/ready handshake, and holds them under stall.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Drives the ALU's a, b and alu_sel inputs, plus sideband outputs (rd, reg_write, store data) to the downstream stage.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush_i  in  1  kill the held instruction (branch redirect).
- in_valid_i  in  1  decode presents an instruction.
- in_ready_o  out  1  stage can accept.
- pc_i  in  XLEN  instruction PC.
- rs1_addr_i, rs2_addr_i  in  REG_AW  source register indices.
- rs1_data_i, rs2_data_i  in  XLEN  register-file read data.
- imm_i  in  XLEN  sign-extended immediate.
- rd_addr_i  in  REG_AW  destination register.
- reg_write_i  in  1  instruction writes rd.
- alu_sel_i  in  4  ALU op code (ALU_* encodings).
- opa_sel_i  in  2  operand-A source.
- opb_sel_i  in  2  operand-B source.
- mem_fwd_we_i  in  1  EX/MEM forward source is valid.
- mem_fwd_rd_i  in  REG_AW  EX/MEM forward source register.
- mem_fwd_data_i  in  XLEN  EX/MEM forward source data.
- wb_fwd_we_i  in  1  MEM/WB write-back is valid.
- wb_fwd_rd_i  in  REG_AW  MEM/WB write-back register.
- wb_fwd_data_i  in  XLEN  MEM/WB write-back data.
- out_valid_o  out  1  instruction valid in EX.
- out_ready_i  in  1  downstream accepts.
- alu_a_o, alu_b_o  out  XLEN  ALU operands.
- alu_sel_o  out  4  ALU op.
- store_data_o  out  XLEN  forwarded rs2 value.
- rd_addr_o  out  REG_AW  destination register.
- reg_write_o  out  1  gated by out_valid_o.
- pc_o  out  XLEN  instruction PC.
- illegal_o  out  1  alu_sel_o == ALU_INVALID while valid.

Behaviour:
- Reset (async, rst=1):
  - valid_q=0.
  - All data/address registers 0.
  - alu_sel_q=ALU_NOP.
  - Outputs follow: alu_a_o=alu_b_o=0, reg_write_o=0, illegal_o=0.
- Handshake:
  - in_ready_o = !valid_q || out_ready_i (combinational).
  - Capture on in_valid_i && in_ready_o; latency 1 cycle to out_valid_o.
  - Transfer out on out_valid_o && out_ready_i.
  - Simultaneous drain and fill gives back-to-back throughput of 1/cycle.
  - Drain with no fill: valid_q<=0.
- Occupancy FSM: EMPTY (valid_q=0) / FULL (valid_q=1).
  - EMPTY -> FULL on capture.
  - FULL -> EMPTY on drain without capture.
  - FULL -> FULL on stall (out_ready_i=0): all registers hold.
- Flush:
  - Highest priority: valid_q<=0 next cycle.
  - A capture requested in the same cycle is dropped.
  - alu_sel_q<=ALU_NOP.
  - in_ready_o is unaffected by flush.
- Bubble: while valid_q=0, alu_sel_o=ALU_NOP, reg_write_o=0, illegal_o=0.
- Operand select:
  - opa_sel: OPA_RS1 -> fwd(rs1); OPA_PC -> pc_q; OPA_ZERO -> 0.
  - opb_sel: OPB_RS2 -> fwd(rs2); OPB_IMM -> imm_q; OPB_FOUR -> 32'd4.
  - Reserved encoding 3 -> 0.
- Forwarding, combinational on the registered rs data, with this priority:
  - rs_addr_q==0 -> 0 (x0 is never forwarded, always 0).
  - Else mem_fwd_we_i && mem_fwd_rd_i==rs_addr_q -> mem data.
  - Else wb_fwd_we_i && wb_fwd_rd_i==rs_addr_q -> wb data.
  - Else the registered value.
- Hold-refresh:
  - While FULL and not draining, if wb_fwd_we_i && wb_fwd_rd_i==rs{1,2}_addr_q != 0, the held rs data register is overwritten with wb_fwd_data_i.
  - This prevents loss of a retiring value during a stall.
- store_data_o = fwd(rs2), independent of opb_sel.
- Arithmetic: none here; all widths are XLEN, no extension.

Optional Feature:
- ID_EX_FWD_EN
- Defined: forwarding and hold-refresh as above.
- Undefined:
  - fwd(rs) returns the registered value (x0 is still forced to 0).
  - No hold-refresh.
  - Forward ports are present but ignored.
  - Hazard stalling is the decoder's responsibility.

Decomposition:
- The shared types package gets:
  - OPA_RS1/OPA_PC/OPA_ZERO and OPB_RS2/OPB_IMM/OPB_FOUR (2-bit).
  - The existing ALU_* op encodings, reused.
- Sub-module fwd_mux:
  - Inputs: rs_addr, rs_data, two forward triples.
  - Output: selected XLEN value.
  - Instantiated twice (rs1, rs2).

Test Plan:
- Reset mid-FULL, with rst asserted asynchronously between edges:
  - out_valid_o=0, alu_sel_o=ALU_NOP, alu_a_o=0 immediately.
- Capture ADD, rs1=x1 (data 5), rs2=x2 (data 7), opa=RS1, opb=RS2, out_ready=1:
  - Next cycle alu_a_o=5, alu_b_o=7, alu_sel_o=ALU_ADD, out_valid_o=1.
- Forward priority: held rs1=x3 (reg data 1), mem_fwd (x3, 0xAA), wb_fwd (x3, 0xBB) both valid -> alu_a_o=0xAA.
  - Drop mem_fwd_we -> 0xBB.
  - With rs1=x0 and both forwards targeting x0 -> 0.
- Stall with hold-refresh: out_ready=0 for 3 cycles, wb writes x4=0x1234 in cycle 1 then deasserts; held rs2=x4.
  - Cycle 3 alu_b_o=0x1234; in_ready_o=0 throughout.
- Flush coinciding with a new capture:
  - Next cycle out_valid_o=0, reg_write_o=0, alu_sel_o=ALU_NOP.
  - The following instruction is captured normally.
- Immediate/PC paths: opa=PC (pc=0x100), opb=FOUR -> alu_a_o=0x100, alu_b_o=4.
  - alu_sel_i=ALU_INVALID -> illegal_o=1.
